// File: rtl/ready_fifo.sv
// Receive-side FWFT buffer terminating a ready-driven pipeline; ready_o drops early
// enough that SKID late beats still fit.
module ready_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SKID  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           data_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic             overflow_q, overflow_d;
    logic             push, pop, full;

    // Next-state: a push into a full FIFO is legal only when a pop frees the slot
    always_comb begin
        pop        = valid_o & ready_i;
        full       = (count_q == CW'(DEPTH));
        push       = valid_i & (~full | pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q | (valid_i & full & ~pop);
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        ready_d = (DEPTH - 32'(count_d)) > SKID;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign valid_o    = (count_q != '0);
    assign data_o     = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign ready_o    = ready_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_ready_fifo.sv
// Directed bench for ready_fifo (DEPTH=8, SKID=2): vector table plus hand sequences.
module tb_ready_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        ready_i = 1'b0;
    logic        ready_o, valid_o, overflow_o;
    logic [31:0] data_o;
    logic [3:0]  count_o;
    logic        run_clk = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    ready_fifo #(.WIDTH(32), .DEPTH(8), .SKID(2)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .data_i(data_i),
        .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o),
        .ready_i(ready_i), .count_o(count_o), .overflow_o(overflow_o)
    );

    initial begin
        wait (run_clk);
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  ec;
        logic        erdy;
        logic        eovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [31:0] d, logic r, logic ev,
                                logic [31:0] ed, logic [3:0] ec, logic erdy, logic eovf);
        vec_t x;
        x.v = v; x.d = d; x.r = r; x.ev = ev; x.ed = ed; x.ec = ec; x.erdy = erdy; x.eovf = eovf;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        valid_i = v;
        data_i  = d;
        ready_i = r;
    endtask

    initial begin
        logic [31:0] exp_q[$];

        // 1. reset with clock stopped
        #2 reset = 1'b1;
        #1;
        check("rst_count", 32'(count_o), 0);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_ready", 32'(ready_o), 1);
        check("rst_ovf",   32'(overflow_o), 0);
        #2 reset = 1'b0;
        #2 run_clk = 1'b1;
        #1;

        // 2. backpressure, overflow and drain
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 32'h100 + 32'(i), 0, 1, 32'h100, 4'(i + 1), (i + 1) < 6, 0));
        tbl.push_back(mk(1, 32'h1FF, 0, 1, 32'h100, 8, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 32'h101, 7, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 32'h102, 6, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 32'h103, 5, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 32'h104, 4, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 32'h105, 3, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 32'h106, 2, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 32'h107, 1, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 32'h0,   0, 1, 1));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r);
            step();
            check($sformatf("v%0d_valid", i), 32'(valid_o), 32'(tbl[i].ev));
            check($sformatf("v%0d_count", i), 32'(count_o), 32'(tbl[i].ec));
            check($sformatf("v%0d_ready", i), 32'(ready_o), 32'(tbl[i].erdy));
            check($sformatf("v%0d_ovf",   i), 32'(overflow_o), 32'(tbl[i].eovf));
            if (tbl[i].ev) check($sformatf("v%0d_data", i), data_o, tbl[i].ed);
        end

        // 6. async reset between edges with count=5 and overflow set
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h200 + 32'(i), 0);
            step();
        end
        drive(0, 0, 0);
        check("pre_rst_count", 32'(count_o), 5);
        check("pre_rst_ovf",   32'(overflow_o), 1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_count", 32'(count_o), 0);
        check("mid_rst_valid", 32'(valid_o), 0);
        check("mid_rst_ready", 32'(ready_o), 1);
        check("mid_rst_ovf",   32'(overflow_o), 0);
        #1 reset = 1'b0;
        step();
        drive(1, 32'h55, 0);
        check("no_bypass_valid", 32'(valid_o), 0);
        step();
        drive(0, 0, 0);
        check("post_rst_valid", 32'(valid_o), 1);
        check("post_rst_data",  data_o, 32'h55);
        drive(0, 0, 1);
        step();
        drive(0, 0, 0);
        check("post_rst_empty", 32'(count_o), 0);

        // 3. FWFT ordering
        drive(1, 32'hA1, 0); step();
        drive(1, 32'hA2, 0); step();
        drive(1, 32'hA3, 0); step();
        drive(0, 0, 1);
        #1 check("fwft_0", data_o, 32'hA1);
        step(); check("fwft_1", data_o, 32'hA2);
        step(); check("fwft_2", data_o, 32'hA3);
        step();
        check("fwft_valid", 32'(valid_o), 0);
        check("fwft_count", 32'(count_o), 0);

        // 4. push and pop while full
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'hB0 + 32'(i), 0);
            step();
            if (i >= 4) exp_q.push_back(32'hB0 + 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'hC0 + 32'(i), 1);
            step();
            exp_q.push_back(32'hC0 + 32'(i));
            check($sformatf("full_pp%0d_count", i), 32'(count_o), 8);
            check($sformatf("full_pp%0d_ovf", i),   32'(overflow_o), 0);
            check($sformatf("full_pp%0d_ready", i), 32'(ready_o), 0);
        end
        drive(0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("full_drain%0d_valid", i), 32'(valid_o), 1);
            check($sformatf("full_drain%0d_data", i), data_o, exp_q[i]);
            step();
        end
        check("full_drain_empty", 32'(valid_o), 0);

        // 5. streaming across pointer wrap
        for (int i = 0; i < 20; i++) begin
            drive(1, 32'(i), 1);
            step();
            check($sformatf("stream%0d_data", i),  data_o, 32'(i));
            check($sformatf("stream%0d_valid", i), 32'(valid_o), 1);
            check($sformatf("stream%0d_count", i), 32'(count_o), 1);
            check($sformatf("stream%0d_ready", i), 32'(ready_o), 1);
        end
        drive(0, 0, 1);
        step();
        check("stream_end_count", 32'(count_o), 0);
        check("stream_end_ovf",   32'(overflow_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
